// File: rtl/sysctrl_master.sv
`default_nettype none
// ============================================================================
// Module      : sysctrl_master
// Description : Initiator side of the system-control byte protocol. It sends
//               a command byte (with start) followed by up to 15 payload
//               bytes, one strobe per GAP+1 cycles. The responder's reply to
//               each payload byte is sampled in the last gap cycle after that
//               byte's strobe.
//               Optional feature macro: SYSCTRL_MASTER_AUTOIRQ_EN. When it is
//               defined and the block is idle, int_n=0 starts an internal
//               interrupt service sequence: read status, read source if
//               status[0] is set, then acknowledge.
// Ports       : clk, reset (sync, active high)
//               cmd_valid/cmd_ready/cmd_code/cmd_len/cmd_payload : request
//               rsp_valid/rsp_data/rsp_index/done                : results
//               data_in_strobe/data_in_start/data_in/data_out    : byte link
//               int_n, irq_status/irq_src/irq_valid              : interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module sysctrl_master #(
  parameter int GAP = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [7:0]   cmd_code,
  input  logic [3:0]   cmd_len,
  input  logic [119:0] cmd_payload,
  output logic         rsp_valid,
  output logic [7:0]   rsp_data,
  output logic [3:0]   rsp_index,
  output logic         done,
  output logic         data_in_strobe,
  output logic         data_in_start,
  output logic [7:0]   data_in,
  input  logic [7:0]   data_out,
  input  logic         int_n,
  output logic [7:0]   irq_status,
  output logic [7:0]   irq_src,
  output logic         irq_valid
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_FIN} state_t;
  state_t state, state_nxt;

  logic [7:0]    code_q;
  logic [3:0]    len_q;
  logic [119:0]  payload_q;
  logic [3:0]    idx_q;
  logic          is_cmd_q;   // the strobe in flight carries the command byte
  logic [GW-1:0] gcnt_q;
  logic [7:0]    hold_q;     // last byte driven, kept on data_in between strobes
  logic          auto_q;     // current transaction belongs to the irq sequence
  logic [1:0]    step_q;     // 0: status read, 1: source read, 2: acknowledge

  logic       auto_req;
  logic       skip_src;
  logic [7:0] byte_sel;
  logic       last_byte;
  logic [1:0] step_nxt;

`ifdef SYSCTRL_MASTER_AUTOIRQ_EN
  logic [7:0] irq_status_q;
  logic [7:0] irq_src_q;
  assign auto_req   = ~int_n;
  assign skip_src   = ~irq_status_q[0];
  assign irq_status = irq_status_q;
  assign irq_src    = irq_src_q;
`else
  logic unused_int_n;
  assign unused_int_n = int_n;
  assign auto_req     = 1'b0;
  assign skip_src     = 1'b1;
  assign irq_status   = 8'h00;
  assign irq_src      = 8'h00;
`endif

  function automatic logic [7:0] auto_code(input logic [1:0] s);
    return (s == 2'd1) ? 8'h06 : 8'h05;
  endfunction

  function automatic logic [7:0] auto_arg(input logic [1:0] s);
    return (s == 2'd2) ? 8'h01 : 8'h00;
  endfunction

  assign byte_sel = is_cmd_q ? code_q : payload_q[{idx_q, 3'b000} +: 8];
  // After the command byte the transaction ends only when there is no payload;
  // after payload byte idx it ends when idx is the final index.
  assign last_byte = is_cmd_q ? (len_q == 4'd0)
                              : (({1'b0, idx_q} + 5'd1) == {1'b0, len_q});
  assign step_nxt  = (step_q == 2'd0 && skip_src) ? 2'd2 : step_q + 2'd1;

  always_comb begin
    state_nxt      = state;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = 8'h00;
    rsp_index      = 4'd0;
    done           = 1'b0;
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
    data_in        = hold_q;
    irq_valid      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid || auto_req) state_nxt = S_STROBE;
      end
      S_STROBE: begin
        data_in_strobe = 1'b1;
        data_in_start  = is_cmd_q;
        data_in        = byte_sel;
        state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        if (gcnt_q == '0) begin
          if (!is_cmd_q && !auto_q) begin
            rsp_valid = 1'b1;
            rsp_data  = data_out;
            rsp_index = idx_q;
          end
          state_nxt = last_byte ? S_FIN : S_STROBE;
        end
      end
      S_FIN: begin
        if (auto_q) begin
          if (step_q == 2'd2) begin
`ifdef SYSCTRL_MASTER_AUTOIRQ_EN
            irq_valid = 1'b1;
`endif
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_STROBE;
          end
        end else begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      code_q    <= 8'h00;
      len_q     <= 4'd0;
      payload_q <= '0;
      idx_q     <= 4'd0;
      is_cmd_q  <= 1'b0;
      gcnt_q    <= '0;
      hold_q    <= 8'h00;
      auto_q    <= 1'b0;
      step_q    <= 2'd0;
`ifdef SYSCTRL_MASTER_AUTOIRQ_EN
      irq_status_q <= 8'h00;
      irq_src_q    <= 8'h00;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          idx_q    <= 4'd0;
          is_cmd_q <= 1'b1;
          if (cmd_valid) begin
            code_q    <= cmd_code;
            len_q     <= cmd_len;
            payload_q <= cmd_payload;
            auto_q    <= 1'b0;
          end else if (auto_req) begin
            code_q    <= auto_code(2'd0);
            len_q     <= 4'd1;
            payload_q <= {112'd0, auto_arg(2'd0)};
            auto_q    <= 1'b1;
            step_q    <= 2'd0;
          end
        end
        S_STROBE: begin
          hold_q <= byte_sel;
          gcnt_q <= GAP_LAST;
        end
        S_WAIT: begin
          if (gcnt_q != '0) begin
            gcnt_q <= gcnt_q - GW'(1);
          end else begin
            if (is_cmd_q) is_cmd_q <= 1'b0;
            else          idx_q    <= idx_q + 4'd1;
`ifdef SYSCTRL_MASTER_AUTOIRQ_EN
            if (auto_q && !is_cmd_q) begin
              if (step_q == 2'd0)      irq_status_q <= data_out;
              else if (step_q == 2'd1) irq_src_q    <= data_out;
            end
`endif
          end
        end
        S_FIN: begin
          // Chain straight into the next irq step without passing IDLE, so
          // an external request cannot interleave with the sequence.
          if (auto_q && step_q != 2'd2) begin
            step_q    <= step_nxt;
            code_q    <= auto_code(step_nxt);
            len_q     <= 4'd1;
            payload_q <= {112'd0, auto_arg(step_nxt)};
            idx_q     <= 4'd0;
            is_cmd_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sysctrl_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysctrl_master
// Description : Self-checking bench for sysctrl_master (GAP=2) with a small
//               responder model. Replies are (payload ^ command), except
//               command 0x06 which always answers 0x01. The responder's
//               interrupt is cleared by command 0x05 with payload 0x01.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysctrl_master;
  localparam int GAP = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_code;
  logic [3:0]   cmd_len;
  logic [119:0] cmd_payload;
  logic         rsp_valid;
  logic [7:0]   rsp_data;
  logic [3:0]   rsp_index;
  logic         done;
  logic         data_in_strobe;
  logic         data_in_start;
  logic [7:0]   data_in;
  logic [7:0]   data_out;
  logic         int_n;
  logic [7:0]   irq_status;
  logic [7:0]   irq_src;
  logic         irq_valid;

  sysctrl_master #(.GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_len(cmd_len), .cmd_payload(cmd_payload),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_index(rsp_index),
    .done(done),
    .data_in_strobe(data_in_strobe), .data_in_start(data_in_start),
    .data_in(data_in), .data_out(data_out),
    .int_n(int_n), .irq_status(irq_status), .irq_src(irq_src),
    .irq_valid(irq_valid)
  );

  always #5 clk = ~clk;

  // Responder model
  logic [7:0] cur_cmd;
  logic       irq_pend;
  logic       irq_raise;
  assign int_n = ~(irq_pend | irq_raise);

  always @(posedge clk) begin
    if (reset) begin
      data_out <= 8'h00;
      cur_cmd  <= 8'h00;
      irq_pend <= 1'b0;
    end else begin
      if (irq_raise) irq_pend <= 1'b1;
      if (data_in_strobe) begin
        if (data_in_start) begin
          cur_cmd <= data_in;
        end else begin
          data_out <= (cur_cmd == 8'h06) ? 8'h01 : (data_in ^ cur_cmd);
          if (cur_cmd == 8'h05 && data_in == 8'h01) irq_pend <= 1'b0;
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [41:0] outs;
  assign outs = {cmd_ready, rsp_valid, rsp_data, rsp_index, done, data_in_strobe,
                 data_in_start, data_in, irq_status, irq_src, irq_valid};

  // Observations of the last transaction
  int         cyc, nstrobe, nrsp, ready_busy, spacing_bad, hold_bad, start_bad, last_s;
  logic       got_done;
  logic [7:0] first_byte, held;
  logic [7:0] rsp_d [16];
  logic [3:0] rsp_ix [16];

  // Accept happens at the end of cycle 0; cyc counts cycles from there.
  task automatic run_txn(input logic [7:0] c, input logic [3:0] l,
                         input logic [119:0] p, input int poke, input logic raise);
    cmd_code = c; cmd_len = l; cmd_payload = p; cmd_valid = 1'b1; irq_raise = raise;
    tick();
    cmd_valid = 1'b0; irq_raise = 1'b0;
    cyc = 1; nstrobe = 0; nrsp = 0; ready_busy = 0; spacing_bad = 0;
    hold_bad = 0; start_bad = 0; last_s = -100; got_done = 1'b0;
    first_byte = 8'h00; held = 8'h00;
    while (!got_done && cyc < 200) begin
      cmd_valid = (cyc == poke);
      if (cyc == poke) cmd_code = 8'hEE;
      if (cmd_ready) ready_busy++;
      if (data_in_start && !data_in_strobe) start_bad++;
      if (data_in_strobe) begin
        if (cyc - last_s < GAP + 1) spacing_bad++;
        if (nstrobe == 0) begin
          first_byte = data_in;
          if (!data_in_start) start_bad++;
        end else if (data_in_start) begin
          start_bad++;
        end
        last_s = cyc; held = data_in; nstrobe++;
      end else if (nstrobe > 0 && data_in !== held) begin
        hold_bad++;
      end
      if (rsp_valid && nrsp < 16) begin
        rsp_d[nrsp] = rsp_data; rsp_ix[nrsp] = rsp_index; nrsp++;
      end
      if (done) got_done = 1'b1;
      else begin tick(); cyc++; end
    end
    cmd_valid = 1'b0;
    tick();  // FIN -> IDLE
  endtask

  typedef struct {
    logic [7:0]   code;
    logic [3:0]   len;
    logic [119:0] payload;
    int           poke;
    int           exp_done;
  } vec_t;

  vec_t vecs [5];

  task automatic check_vec(input vec_t v, input string tag);
    logic [7:0] e;
    chk({tag, "_done_cycle"}, cyc, v.exp_done);
    chk({tag, "_first_byte"}, first_byte, v.code);
    chk({tag, "_strobes"}, nstrobe, v.len + 1);
    chk({tag, "_rsp_count"}, nrsp, v.len);
    chk({tag, "_start_only_first"}, start_bad, 0);
    chk({tag, "_ready_low_busy"}, ready_busy, 0);
    chk({tag, "_strobe_spacing"}, spacing_bad, 0);
    chk({tag, "_data_hold"}, hold_bad, 0);
    for (int i = 0; i < int'(v.len) && i < nrsp; i++) begin
      e = v.payload[i*8 +: 8] ^ v.code;
      chk({tag, "_rsp_data"}, rsp_d[i], e);
      chk({tag, "_rsp_index"}, rsp_ix[i], i);
    end
  endtask

  initial begin
    int n, n_irq, n_ext, n_str;
    vecs[0] = '{8'h00, 4'd3,  120'h00425C, 0, 13};   // status read: 5C 42 00
    vecs[1] = '{8'h04, 4'd2,  120'h0253,   2, 10};   // config write, poked in WAIT
    vecs[2] = '{8'h01, 4'd0,  120'h0,      0, 4};    // zero length
    vecs[3] = '{8'h0A, 4'd15, 120'h0102030405060708090A0B0C0D0E0F, 5, 49};
    vecs[4] = '{8'h33, 4'd1,  120'hFF,     0, 7};

    reset = 1'b1; cmd_valid = 1'b0; cmd_code = 8'h00; cmd_len = 4'd0;
    cmd_payload = '0; irq_raise = 1'b0;
    tick(); tick();
    chk("reset_outputs", outs, {1'b1, 41'd0});
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].code, vecs[v].len, vecs[v].payload, vecs[v].poke, 1'b0);
      check_vec(vecs[v], $sformatf("vec%0d", v));
      n = 0;
      repeat (4) begin
        if (data_in_strobe || !cmd_ready) n++;
        tick();
      end
      chk($sformatf("vec%0d_idle_after", v), n, 0);
    end

    // Reset in the middle of a len=5 transaction
    cmd_code = 8'h21; cmd_len = 4'd5; cmd_payload = 120'h5566778899; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    chk("reset_mid_outputs", outs, {1'b1, 41'd0});
    reset = 1'b0;
    n = 0;
    repeat (8) begin
      if (data_in_strobe || done || rsp_valid) n++;
      tick();
    end
    chk("reset_mid_quiet", n, 0);
    run_txn(vecs[0].code, vecs[0].len, vecs[0].payload, 0, 1'b0);
    check_vec(vecs[0], "after_reset");

    // External command and interrupt arrive together
    run_txn(8'h00, 4'd2, 120'h0201, 0, 1'b1);
    chk("prio_first_byte", first_byte, 8'h00);
    chk("prio_done_cycle", cyc, 10);
    chk("prio_rsp_count", nrsp, 2);
    chk("prio_rsp0", rsp_d[0], 8'h01);
    chk("prio_rsp1", rsp_d[1], 8'h02);

    n_irq = 0; n_ext = 0; n_str = 0;
    for (int k = 0; k < 120; k++) begin
      if (irq_valid) n_irq++;
      if (rsp_valid || done) n_ext++;
      if (data_in_strobe) n_str++;
      tick();
    end
`ifdef SYSCTRL_MASTER_AUTOIRQ_EN
    chk("auto_irq_valid_pulses", n_irq, 1);
    chk("auto_no_ext_pulses", n_ext, 0);
    chk("auto_strobes", n_str, 6);
    chk("auto_irq_status", irq_status, 8'h05);
    chk("auto_irq_src", irq_src, 8'h01);
    chk("auto_int_released", int_n, 1'b1);
`else
    chk("noirq_irq_valid", n_irq, 0);
    chk("noirq_no_ext_pulses", n_ext, 0);
    chk("noirq_no_strobes", n_str, 0);
    chk("noirq_irq_status", irq_status, 8'h00);
    chk("noirq_irq_src", irq_src, 8'h00);
    chk("noirq_ready", cmd_ready, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
